// File: rtl/cp0_except_unit.sv
// CP0 exception/interrupt unit: BadVAddr, Count, Compare, Status, Cause and EPC with MEM-stage exception commit.
// Optional timer (Count/Compare/TI) is enabled by defining CP0_TIMER_EN.
module cp0_except_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [8:0]  mem_except,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_badvaddr,
    input  logic        mem_in_delay_slot,
    input  logic [5:0]  ext_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        int_pending
);

    logic [31:0] badvaddr, epc;
    logic [7:0]  status_im;
    logic        status_exl, status_ie;
    logic        cause_bd, cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc;
    logic [31:0] status_rd, cause_rd, count_rd, compare_rd;

    logic        exc_taken, eret_taken, sel_if, sel_dmem;
    logic [4:0]  exc_code;

    assign status_rd = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_rd  = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'b00};

    // Eret is excluded from the exception set so any real fault beside it wins.
    assign exc_taken  = mem_valid & (|(mem_except & 9'h1F7));
    assign eret_taken = mem_valid & mem_except[3] & ~exc_taken;

    assign flush       = resetn & (exc_taken | eret_taken);
    assign flush_pc    = exc_taken ? EXC_VECTOR : epc;
    assign int_pending = resetn & (|({cause_ip_hw, cause_ip_sw} & status_im)) & status_ie & ~status_exl;

    always_comb begin
        exc_code = 5'h00;
        sel_if   = 1'b0;
        sel_dmem = 1'b0;
        if (mem_except[8])      exc_code = 5'h00;
        else if (mem_except[7]) begin exc_code = 5'h04; sel_if = 1'b1; end
        else if (mem_except[6]) exc_code = 5'h0A;
        else if (mem_except[0]) exc_code = 5'h0C;
        else if (mem_except[5]) exc_code = 5'h08;
        else if (mem_except[4]) exc_code = 5'h09;
        else if (mem_except[1]) begin exc_code = 5'h04; sel_dmem = 1'b1; end
        else if (mem_except[2]) begin exc_code = 5'h05; sel_dmem = 1'b1; end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            badvaddr    <= '0;
            epc         <= '0;
            status_im   <= '0;
            status_exl  <= 1'b0;
            status_ie   <= 1'b0;
            cause_bd    <= 1'b0;
            cause_ip_hw <= '0;
            cause_ip_sw <= '0;
            cause_exc   <= '0;
        end else begin
            cause_ip_hw <= {ext_int[5] | cause_ti, ext_int[4:0]};
            if (cp0_we) begin
                case (cp0_waddr)
                    5'd12: begin
                        // IE is kept writable since the interrupt gate depends on it.
                        status_im  <= cp0_wdata[15:8];
                        status_exl <= cp0_wdata[1];
                        status_ie  <= cp0_wdata[0];
                    end
                    5'd13: cause_ip_sw <= cp0_wdata[9:8];
                    5'd14: epc         <= cp0_wdata;
                    default: ;
                endcase
            end
            // Placed after the MTC0 case so exception/Eret updates override a same-cycle write.
            if (exc_taken) begin
                status_exl <= 1'b1;
                cause_exc  <= exc_code;
                if (!status_exl) begin
                    epc      <= mem_in_delay_slot ? mem_pc - 32'd4 : mem_pc;
                    cause_bd <= mem_in_delay_slot;
                end
                if (sel_if)
                    badvaddr <= mem_pc;
                else if (sel_dmem)
                    badvaddr <= mem_badvaddr;
            end else if (eret_taken) begin
                status_exl <= 1'b0;
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count, compare;
    logic        tick;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count    <= '0;
            compare  <= '0;
            tick     <= 1'b0;
            cause_ti <= 1'b0;
        end else begin
            if (cp0_we && cp0_waddr == 5'd9) begin
                count <= cp0_wdata;
                tick  <= 1'b0;
            end else begin
                tick <= ~tick;
                if (tick)
                    count <= count + 32'd1;
            end
            if (cp0_we && cp0_waddr == 5'd11) begin
                compare  <= cp0_wdata;
                cause_ti <= 1'b0;
            end else if (count == compare) begin
                cause_ti <= 1'b1;
            end
        end
    end

    assign count_rd   = count;
    assign compare_rd = compare;
`else
    assign count_rd   = '0;
    assign compare_rd = '0;
    assign cause_ti   = 1'b0;
`endif

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            5'd8:    cp0_rdata = badvaddr;
            5'd9:    cp0_rdata = count_rd;
            5'd11:   cp0_rdata = compare_rd;
            5'd12:   cp0_rdata = status_rd;
            5'd13:   cp0_rdata = cause_rd;
            5'd14:   cp0_rdata = epc;
            default: cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_except_unit.sv
// Directed self-checking bench for cp0_except_unit.
`timescale 1ns/1ps
module tb_cp0_except_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic [8:0]  mem_except;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_badvaddr;
    logic        mem_in_delay_slot;
    logic [5:0]  ext_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        int_pending;

    int unsigned errors = 0;
    int unsigned checks = 0;

    cp0_except_unit #(.EXC_VECTOR(32'hBFC0_0380)) dut (
        .clk(clk), .resetn(resetn), .mem_except(mem_except), .mem_valid(mem_valid),
        .mem_pc(mem_pc), .mem_badvaddr(mem_badvaddr), .mem_in_delay_slot(mem_in_delay_slot),
        .ext_int(ext_int), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .flush(flush), .flush_pc(flush_pc),
        .int_pending(int_pending)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_raddr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
        step();
        cp0_we = 1'b0;
    endtask

    task automatic mem_op(input logic v, input logic [8:0] e, input logic [31:0] pc,
                          input logic [31:0] bad, input logic ds);
        mem_valid = v; mem_except = e; mem_pc = pc; mem_badvaddr = bad; mem_in_delay_slot = ds;
        #1;
    endtask

    task automatic mem_idle();
        mem_valid = 1'b0; mem_except = '0;
    endtask

    initial begin
        logic [31:0] v;
        int unsigned n;
        bit seen;

        resetn = 1'b0; mem_except = '0; mem_valid = 1'b0; mem_pc = '0; mem_badvaddr = '0;
        mem_in_delay_slot = 1'b0; ext_int = '0; cp0_we = 1'b0; cp0_waddr = '0;
        cp0_wdata = '0; cp0_raddr = '0;
        step(); step();

        chk_reg("rst_status", 5'd12, 32'h0040_0000);
        chk_reg("rst_cause", 5'd13, 32'h0000_0000);
        chk_reg("rst_epc", 5'd14, 32'h0000_0000);
        chk_reg("rst_badvaddr", 5'd8, 32'h0000_0000);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_int_pending", {31'b0, int_pending}, 32'd0);
        resetn = 1'b1;
        step();

        // Overflow exception, EXL clear
        mem_op(1'b1, 9'h001, 32'hBFC0_1000, 32'h0, 1'b0);
        chk("ov_flush", {31'b0, flush}, 32'd1);
        chk("ov_flush_pc", flush_pc, 32'hBFC0_0380);
        step(); mem_idle();
        chk_reg("ov_epc", 5'd14, 32'hBFC0_1000);
        rd(5'd13, v);
        chk("ov_exccode", {27'b0, v[6:2]}, 32'h0C);
        chk("ov_bd", {31'b0, v[31]}, 32'd0);
        chk_reg("ov_status", 5'd12, 32'h0040_0002);
        chk("idle_flush", {31'b0, flush}, 32'd0);

        // Eret returns to EPC and clears EXL
        mem_op(1'b1, 9'h008, 32'h0, 32'h0, 1'b0);
        chk("eret_flush", {31'b0, flush}, 32'd1);
        chk("eret_flush_pc", flush_pc, 32'hBFC0_1000);
        step(); mem_idle();
        chk_reg("eret_status", 5'd12, 32'h0040_0000);

        // Rd+Wr address error in a delay slot
        mem_op(1'b1, 9'h006, 32'hBFC0_2004, 32'h8000_0003, 1'b1);
        chk("adel_flush_pc", flush_pc, 32'hBFC0_0380);
        step(); mem_idle();
        rd(5'd13, v);
        chk("adel_exccode", {27'b0, v[6:2]}, 32'h04);
        chk("adel_bd", {31'b0, v[31]}, 32'd1);
        chk_reg("adel_badvaddr", 5'd8, 32'h8000_0003);
        chk_reg("adel_epc", 5'd14, 32'hBFC0_2000);

        // Nested Break with EXL=1: EPC/BD/BadVAddr hold
        mem_op(1'b1, 9'h010, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
        step(); mem_idle();
        rd(5'd13, v);
        chk("nest_exccode", {27'b0, v[6:2]}, 32'h09);
        chk("nest_bd", {31'b0, v[31]}, 32'd1);
        chk_reg("nest_epc", 5'd14, 32'hBFC0_2000);
        chk_reg("nest_badvaddr", 5'd8, 32'h8000_0003);

        // Syscall alongside Eret: exception wins
        mem_op(1'b1, 9'h028, 32'hBFC0_2100, 32'h0, 1'b0);
        chk("sys_eret_flush_pc", flush_pc, 32'hBFC0_0380);
        step(); mem_idle();
        rd(5'd13, v);
        chk("sys_eret_exccode", {27'b0, v[6:2]}, 32'h08);
        chk_reg("sys_eret_status", 5'd12, 32'h0040_0002);

        mem_op(1'b1, 9'h008, 32'h0, 32'h0, 1'b0);
        chk("eret2_flush_pc", flush_pc, 32'hBFC0_2000);
        step(); mem_idle();

        // Fetch address error beats RI and Overflow
        mem_op(1'b1, 9'h0C1, 32'hBFC0_3000, 32'h5555_5555, 1'b0);
        step(); mem_idle();
        rd(5'd13, v);
        chk("adif_exccode", {27'b0, v[6:2]}, 32'h04);
        chk("adif_bd", {31'b0, v[31]}, 32'd0);
        chk_reg("adif_badvaddr", 5'd8, 32'hBFC0_3000);
        chk_reg("adif_epc", 5'd14, 32'hBFC0_3000);

        // mem_valid low: everything ignored
        mem_op(1'b0, 9'h1FF, 32'hAAAA_0000, 32'hBBBB_0000, 1'b1);
        chk("novalid_flush", {31'b0, flush}, 32'd0);
        step(); mem_idle();
        rd(5'd13, v);
        chk("novalid_exccode", {27'b0, v[6:2]}, 32'h04);
        chk_reg("novalid_epc", 5'd14, 32'hBFC0_3000);
        chk_reg("novalid_badvaddr", 5'd8, 32'hBFC0_3000);

        mem_op(1'b1, 9'h008, 32'h0, 32'h0, 1'b0);
        step(); mem_idle();

        // MTC0 EPC collides with Syscall: exception wins
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h1111_1111;
        mem_op(1'b1, 9'h020, 32'hBFC0_4000, 32'h0, 1'b0);
        step(); mem_idle(); cp0_we = 1'b0;
        chk_reg("mtc0_vs_exc_epc", 5'd14, 32'hBFC0_4000);

        // MTC0 Status collides with Eret; read in write cycle sees old value
        cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0403;
        mem_op(1'b1, 9'h008, 32'h0, 32'h0, 1'b0);
        chk("mtc0_eret_flush_pc", flush_pc, 32'hBFC0_4000);
        chk_reg("mtc0_old_read", 5'd12, 32'h0040_0002);
        step(); mem_idle(); cp0_we = 1'b0;
        chk_reg("mtc0_vs_eret_status", 5'd12, 32'h0040_0401);

        // Unimplemented register
        wr(5'd5, 32'hFFFF_FFFF);
        chk_reg("unimpl_read", 5'd5, 32'h0);

        // Interrupt path
        ext_int = 6'b000001;
        #1;
        chk("int_not_yet", {31'b0, int_pending}, 32'd0);
        step(); step();
        chk("int_pending_set", {31'b0, int_pending}, 32'd1);
        rd(5'd13, v);
        chk("int_ip10", {31'b0, v[10]}, 32'd1);
        mem_op(1'b1, 9'h100, 32'hBFC0_5000, 32'h0, 1'b0);
        chk("int_exc_flush", {31'b0, flush}, 32'd1);
        step(); mem_idle();
        rd(5'd13, v);
        chk("int_exccode", {27'b0, v[6:2]}, 32'h00);
        chk("int_masked_by_exl", {31'b0, int_pending}, 32'd0);

`ifdef CP0_TIMER_EN
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        rd(5'd13, v);
        chk("timer_ti_clear", {31'b0, v[30]}, 32'd0);
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            step(); n++;
            rd(5'd13, v);
            seen = v[30];
        end
        chk("timer_ti_latency", n, 32'd11);
        step();
        rd(5'd13, v);
        chk("timer_ip15", {31'b0, v[15]}, 32'd1);
        wr(5'd11, 32'd1000);
        rd(5'd13, v);
        chk("timer_ti_cleared", {31'b0, v[30]}, 32'd0);
`else
        wr(5'd9, 32'd123);
        wr(5'd11, 32'd77);
        chk_reg("no_timer_count", 5'd9, 32'h0);
        chk_reg("no_timer_compare", 5'd11, 32'h0);
        rd(5'd13, v);
        chk("no_timer_ti", {31'b0, v[30]}, 32'd0);
`endif

        // Re-arm int_pending, then reset over an in-flight Overflow
        mem_op(1'b1, 9'h008, 32'h0, 32'h0, 1'b0);
        step(); mem_idle();
        chk("int_pending_rearm", {31'b0, int_pending}, 32'd1);
        resetn = 1'b0;
        mem_op(1'b1, 9'h001, 32'hBFC0_6000, 32'h0, 1'b0);
        chk("rst_ov_flush", {31'b0, flush}, 32'd0);
        chk("rst_ov_int_pending", {31'b0, int_pending}, 32'd0);
        step();
        chk_reg("rst2_status", 5'd12, 32'h0040_0000);
        chk_reg("rst2_cause", 5'd13, 32'h0);
        chk_reg("rst2_epc", 5'd14, 32'h0);
        chk_reg("rst2_badvaddr", 5'd8, 32'h0);
        chk_reg("rst2_count", 5'd9, 32'h0);
        chk_reg("rst2_compare", 5'd11, 32'h0);
        chk("rst2_flush", {31'b0, flush}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
